// File: rtl/ecc_pkg.sv
`default_nettype none
// ============================================================================
// Module : ecc_pkg
// Brief  : SEC code definitions shared by the write encoder and read decoder.
// Rev    : 1.0
// ============================================================================
package ecc_pkg;

  localparam int ECC_DATA_W = 128;
  localparam int ECC_CODE_W = 8;

  // Partial code[6:0] over one 32-bit quarter; base is the index of q[0].
  // XOR-ing the 1-based position of every set bit equals the per-bit rule.
  function automatic logic [6:0] ecc_partial(input logic [31:0] q, input int base);
    logic [6:0] p;
    int         pos;
    p = '0;
    for (int j = 0; j < 32; j++) begin
      pos = base + j + 1;
      if (pos <= 127 && q[j]) p = p ^ pos[6:0];
    end
    return p;
  endfunction

  function automatic logic [ECC_CODE_W-1:0] ecc_calc(input logic [ECC_DATA_W-1:0] d);
    logic [6:0] c;
    c = '0;
    for (int q = 0; q < 4; q++) c = c ^ ecc_partial(d[32*q +: 32], 32*q);
    return {d[127], c};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ecc_write_encoder_if.sv
`default_nettype none
// ============================================================================
// Module : ecc_write_encoder_if
// Brief  : Input stream, injection control and SRAM-side output stream.
// Rev    : 1.0
// ============================================================================
interface ecc_write_encoder_if
  import ecc_pkg::*;
#(
  parameter int ADDR_W = 11
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_W-1:0]     in_addr;
  logic [ECC_DATA_W-1:0] in_data;
  logic                  inj_arm;
  logic [7:0]            inj_bit;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_W-1:0]     out_addr;
  logic [ECC_DATA_W-1:0] out_data;
  logic [ECC_CODE_W-1:0] out_code;

  modport master (
    output in_valid, in_addr, in_data, inj_arm, inj_bit, out_ready,
    input  in_ready, out_valid, out_addr, out_data, out_code
  );

  modport slave (
    input  in_valid, in_addr, in_data, inj_arm, inj_bit, out_ready,
    output in_ready, out_valid, out_addr, out_data, out_code
  );
endinterface
`default_nettype wire

// File: rtl/ecc_write_encoder.sv
`default_nettype none
// ============================================================================
// Module : ecc_write_encoder
// Brief  : Two-stage SEC encoder with one-shot error injection and a
//          saturating count of words written to the SRAM arbiter.
// Rev    : 1.0
// ============================================================================
module ecc_write_encoder
  import ecc_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ecc_write_encoder_if.slave      bus,
  output logic                    inj_pending,
  output logic [CNT_W-1:0]        wr_count
);

  logic                  r_s1_valid;
  logic [ADDR_W-1:0]     r_s1_addr;
  logic [ECC_DATA_W-1:0] r_s1_data;
  logic [3:0][6:0]       r_s1_part;
  logic                  r_s1_inj_en;
  logic [7:0]            r_s1_inj_bit;

  logic                  r_s2_valid;
  logic [ADDR_W-1:0]     r_s2_addr;
  logic [ECC_DATA_W-1:0] r_s2_data;
  logic [ECC_CODE_W-1:0] r_s2_code;

  logic                  r_inj_pending;
  logic [7:0]            r_inj_bit;
  logic [CNT_W-1:0]      r_wr_count;

  logic                  w_s2_load;
  logic                  w_accept;
  logic                  w_inj_en;
  logic [7:0]            w_inj_bit;
  logic [3:0][6:0]       w_part;
  logic [ECC_CODE_W-1:0] w_code;
  logic [ECC_DATA_W-1:0] w_flip_data;
  logic [ECC_CODE_W-1:0] w_flip_code;

  assign w_s2_load    = !r_s2_valid || bus.out_ready;
  assign bus.in_ready = !r_s1_valid || w_s2_load;
  assign w_accept     = bus.in_valid && bus.in_ready;

  // An arm in the accepting cycle wins over the latched bit.
  assign w_inj_en  = bus.inj_arm || r_inj_pending;
  assign w_inj_bit = bus.inj_arm ? bus.inj_bit : r_inj_bit;

  for (genvar q = 0; q < 4; q++) begin : g_part
    assign w_part[q] = ecc_partial(bus.in_data[32*q +: 32], 32*q);
  end

  assign w_code = {r_s1_data[127], r_s1_part[0] ^ r_s1_part[1] ^ r_s1_part[2] ^ r_s1_part[3]};

  // Bits 0..127 hit data, 128..135 hit code, anything above is a no-op.
  assign w_flip_data = (r_s1_inj_en && !r_s1_inj_bit[7])
                     ? (ECC_DATA_W'(1) << r_s1_inj_bit[6:0]) : '0;
  assign w_flip_code = (r_s1_inj_en && r_s1_inj_bit[7:3] == 5'b10000)
                     ? (ECC_CODE_W'(1) << r_s1_inj_bit[2:0]) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid    <= 1'b0;
      r_s1_addr     <= '0;
      r_s1_data     <= '0;
      r_s1_part     <= '0;
      r_s1_inj_en   <= 1'b0;
      r_s1_inj_bit  <= '0;
      r_s2_valid    <= 1'b0;
      r_s2_addr     <= '0;
      r_s2_data     <= '0;
      r_s2_code     <= '0;
      r_inj_pending <= 1'b0;
      r_inj_bit     <= '0;
      r_wr_count    <= '0;
    end else begin
      if (bus.in_ready) r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_addr    <= bus.in_addr;
        r_s1_data    <= bus.in_data;
        r_s1_part    <= w_part;
        r_s1_inj_en  <= w_inj_en;
        r_s1_inj_bit <= w_inj_bit;
      end

      if (w_accept) begin
        r_inj_pending <= 1'b0;
      end else if (bus.inj_arm) begin
        r_inj_pending <= 1'b1;
        r_inj_bit     <= bus.inj_bit;
      end

      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_addr <= r_s1_addr;
          r_s2_data <= r_s1_data ^ w_flip_data;
          r_s2_code <= w_code ^ w_flip_code;
        end
      end

      if (r_s2_valid && bus.out_ready && r_wr_count != '1)
        r_wr_count <= r_wr_count + CNT_W'(1);
    end
  end

  assign bus.out_valid = r_s2_valid;
  assign bus.out_addr  = r_s2_addr;
  assign bus.out_data  = r_s2_data;
  assign bus.out_code  = r_s2_code;
  assign inj_pending   = r_inj_pending;
  assign wr_count      = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_ecc_write_encoder.sv
`default_nettype none
// ============================================================================
// Module : tb_ecc_write_encoder
// Brief  : Directed and randomized checks of ecc_write_encoder against a
//          queue-based reference model.
// Rev    : 1.0
// ============================================================================
module tb_ecc_write_encoder;

  localparam int ADDR_W = 11;
  localparam int CNT_W  = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic inj_pending;
  logic [CNT_W-1:0] wr_count;

  always #5 clk = ~clk;

  ecc_write_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  ecc_write_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .inj_pending (inj_pending),
    .wr_count    (wr_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hamming view: the syndrome is the XOR of the 1-based positions of set bits.
  function automatic logic [7:0] ref_code(input logic [127:0] d);
    logic [7:0] s;
    s = 8'h00;
    for (int k = 0; k < 127; k++) if (d[k]) s = s ^ 8'(k + 1);
    s[7] = d[127];
    return s;
  endfunction

  // ---------------- reference model and compare process ----------------
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [127:0]      d;
    logic [7:0]        c;
    int                age;
  } word_t;

  word_t      q[$];
  int         m_count;
  bit         m_pend;
  logic [7:0] m_pbit;

  always @(negedge clk) begin
    bit         exp_rdy, exp_ov, use_inj;
    logic [7:0] b;
    word_t      w;
    if (!rst_n) begin
      q.delete();
      m_count = 0;
      m_pend  = 0;
      m_pbit  = 8'h00;
      chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
      chk("rst_wr_count", 128'(wr_count), 128'(0));
      chk("rst_inj_pending", 128'(inj_pending), 128'(0));
    end else begin
      exp_rdy = (q.size() < 2) || bus.out_ready;
      exp_ov  = (q.size() > 0) && (q[0].age >= 2);
      chk("in_ready", 128'(bus.in_ready), 128'(exp_rdy));
      chk("out_valid", 128'(bus.out_valid), 128'(exp_ov));
      if (exp_ov) begin
        chk("out_addr", 128'(bus.out_addr), 128'(q[0].a));
        chk("out_data", bus.out_data, q[0].d);
        chk("out_code", 128'(bus.out_code), 128'(q[0].c));
      end
      chk("wr_count", 128'(wr_count), 128'(m_count));
      chk("inj_pending", 128'(inj_pending), 128'(m_pend));

      if (exp_ov && bus.out_ready) begin
        void'(q.pop_front());
        if (m_count < CNT_MAX) m_count++;
      end
      foreach (q[i]) q[i].age++;
      if (bus.in_valid && exp_rdy) begin
        w.a = bus.in_addr;
        w.d = bus.in_data;
        w.c = ref_code(bus.in_data);
        w.age = 1;
        use_inj = bus.inj_arm || m_pend;
        b = bus.inj_arm ? bus.inj_bit : m_pbit;
        if (use_inj && b < 128) w.d[b] = ~w.d[b];
        else if (use_inj && b < 136) w.c[b - 128] = ~w.c[b - 128];
        q.push_back(w);
        m_pend = 0;
      end else if (bus.inj_arm) begin
        m_pend = 1;
        m_pbit = bus.inj_bit;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input logic [127:0] d, input logic [ADDR_W-1:0] a,
                       input bit ordy, input bit arm, input logic [7:0] ib);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_addr   = a;
    bus.out_ready = ordy;
    bus.inj_arm   = arm;
    bus.inj_bit   = ib;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 8'h00);
  endtask

  // Word in cycle N, idle N+1..N+2, returns at the negedge of N+2 (output visible).
  task automatic send_one(input logic [127:0] d, input bit arm, input logic [7:0] ib);
    drive(1'b1, d, 11'h5A, 1'b1, arm, ib);
    idle();
    idle();
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.inj_arm = 1'b0;
    #1;
    chk("async_rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("async_rst_wr_count", 128'(wr_count), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [127:0] lit_d [5];
  logic [7:0]   lit_c [5];

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_addr = '0;
    bus.out_ready = 1'b0; bus.inj_arm = 1'b0; bus.inj_bit = 8'h00;

    lit_d[0] = '0;           lit_c[0] = 8'h00;
    lit_d[1] = 128'd1;       lit_c[1] = 8'h01;
    lit_d[2] = 128'd1 << 126; lit_c[2] = 8'h7F;
    lit_d[3] = 128'd1 << 127; lit_c[3] = 8'h80;
    lit_d[4] = '1;           lit_c[4] = 8'h80;
    for (int i = 0; i < 5; i++) chk("model_code_lit", 128'(ref_code(lit_d[i])), 128'(lit_c[i]));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_data", bus.out_data, '0);
    chk("reset_out_code", 128'(bus.out_code), 128'(0));
    chk("reset_out_addr", 128'(bus.out_addr), 128'(0));
    @(posedge clk); #1; rst_n = 1'b1;
    #1 chk("ready_after_reset", 128'(bus.in_ready), 128'(1));

    // Code literals, exact two-cycle latency
    for (int i = 0; i < 5; i++) begin
      send_one(lit_d[i], 1'b0, 8'h00);
      chk("lit_out_valid", 128'(bus.out_valid), 128'(1));
      chk("lit_out_code", 128'(bus.out_code), 128'(lit_c[i]));
    end

    // Back-to-back stream of 8 words
    reset_pulse();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, {4{32'(i * 32'h1111_0101)}}, ADDR_W'(i), 1'b1, 1'b0, 8'h00);
      @(negedge clk);
      if (i == 1) chk("stream_lat_early", 128'(bus.out_valid), 128'(0));
      if (i == 2) begin
        chk("stream_lat_first", 128'(bus.out_valid), 128'(1));
        chk("stream_first_addr", 128'(bus.out_addr), 128'(0));
      end
    end
    repeat (3) idle();
    @(negedge clk);
    chk("stream_wr_count", 128'(wr_count), 128'(8));

    // Stall: 3 words offered, only 2 fit
    drive(1'b1, 128'hA1, 11'd1, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 128'hA2, 11'd2, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 128'hA3, 11'd3, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      chk("stall_in_ready", 128'(bus.in_ready), 128'(0));
      chk("stall_hold_data", bus.out_data, 128'hA1);
    end
    drive(1'b1, 128'hA3, 11'd3, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("unstall_in_ready", 128'(bus.in_ready), 128'(1));
    repeat (4) idle();

    // Injection
    send_one('0, 1'b1, 8'd5);
    chk("inj5_data", bus.out_data, 128'h20);
    chk("inj5_code", 128'(bus.out_code), 128'(0));
    chk("inj5_pending", 128'(inj_pending), 128'(0));
    drive(1'b0, '0, '0, 1'b1, 1'b1, 8'd130);
    idle();
    @(negedge clk);
    chk("inj130_pending", 128'(inj_pending), 128'(1));
    send_one('0, 1'b0, 8'h00);
    chk("inj130_code", 128'(bus.out_code), 128'(8'h04));
    chk("inj130_data", bus.out_data, '0);
    drive(1'b0, '0, '0, 1'b1, 1'b1, 8'd200);
    send_one('0, 1'b0, 8'h00);
    chk("inj200_code", 128'(bus.out_code), 128'(0));
    chk("inj200_data", bus.out_data, '0);
    chk("inj200_pending", 128'(inj_pending), 128'(0));
    drive(1'b0, '0, '0, 1'b1, 1'b1, 8'd5);
    drive(1'b0, '0, '0, 1'b1, 1'b1, 8'd7);
    send_one('0, 1'b0, 8'h00);
    chk("rearm_data", bus.out_data, 128'h80);

    // Reset while both stages are full and stalled
    drive(1'b1, 128'hB1, 11'd1, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 128'hB2, 11'd2, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 128'hB3, 11'd3, 1'b0, 1'b0, 8'h00);
    reset_pulse();
    send_one(128'd1, 1'b0, 8'h00);
    chk("post_rst_code", 128'(bus.out_code), 128'(8'h01));
    chk("post_rst_data", bus.out_data, 128'd1);
    idle();
    @(negedge clk);
    chk("post_rst_wr_count", 128'(wr_count), 128'(1));

    // Randomized traffic (also drives wr_count into saturation)
    for (int c = 0; c < 2000; c++) begin
      logic [127:0] d;
      case ($urandom_range(0, 5))
        0:       d = '0;
        1:       d = '1;
        2:       d = 128'd1 << $urandom_range(0, 127);
        default: d = {$urandom, $urandom, $urandom, $urandom};
      endcase
      drive($urandom_range(0, 3) != 0, d, ADDR_W'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0,
            ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 140)));
    end
    repeat (6) idle();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
